left_shift_1b: RTL and testbench



---
 rtl/left_shift_1b_pkg.sv | 19 +
 rtl/left_shift_1b_if.sv | 39 +++
 rtl/left_shift_1b_shl1_core.sv | 26 ++
 rtl/left_shift_1b.sv | 66 ++++++
 tb/tb_left_shift_1b.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/left_shift_1b_pkg.sv
// -----------------------------------------------------------------------------
// left_shift_1b_pkg
// Shared constants for the immediate path: the default data width used by
// the sign-extender, this shift-left-by-one unit and the branch-target adder.
// No ports (package).
// -----------------------------------------------------------------------------
package left_shift_1b_pkg;

    // Default width of immediates and shifted results on the immediate path.
    localparam int DEFAULT_WIDTH = 16;

    // Convenience type for a default-width immediate.
    typedef logic [DEFAULT_WIDTH-1:0] imm_t;

    // Value of the registered zero flag while in reset: out is cleared to 0,
    // so the flag must agree and read as "result is zero".
    localparam logic RESET_ZERO = 1'b1;

endpackage : left_shift_1b_pkg

// File: rtl/left_shift_1b_if.sv
// -----------------------------------------------------------------------------
// left_shift_1b_if
// Bundles the operand and result signals of the shift-left-by-one unit.
//   immediate  operand (WIDTH bits), sampled when in_valid is high
//   in_valid   operand qualifier
//   out        registered shifted result (WIDTH bits)
//   out_valid  result/flags valid this cycle
//   carry_out  registered bit shifted out (immediate MSB)
//   zero       registered flag, shifted result is all zeros
// Modports: master drives the operand side, slave is the shift unit.
// -----------------------------------------------------------------------------
interface left_shift_1b_if #(
    parameter int WIDTH = left_shift_1b_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] immediate;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             carry_out;
    logic             zero;

    modport master (
        output immediate,
        output in_valid,
        input  out,
        input  out_valid,
        input  carry_out,
        input  zero
    );

    modport slave (
        input  immediate,
        input  in_valid,
        output out,
        output out_valid,
        output carry_out,
        output zero
    );
endinterface : left_shift_1b_if

// File: rtl/left_shift_1b_shl1_core.sv
// -----------------------------------------------------------------------------
// left_shift_1b_shl1_core
// Purely combinational logical shift left by one (zero fill).
//   immediate  in   WIDTH  operand
//   shifted    out  WIDTH  {immediate[WIDTH-2:0], 1'b0}
//   carry      out  1      immediate[WIDTH-1], the bit shifted out
//   zero       out  1      shifted == 0
// -----------------------------------------------------------------------------
module left_shift_1b_shl1_core
    import left_shift_1b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] immediate,
    output logic [WIDTH-1:0] shifted,
    output logic             carry,
    output logic             zero
);

    assign shifted = {immediate[WIDTH-2:0], 1'b0};
    assign carry   = immediate[WIDTH-1];
    // Bit 0 of the result is always 0, so only the surviving operand bits
    // decide the flag; this is why 2^(WIDTH-1) also yields zero.
    assign zero    = ~|immediate[WIDTH-2:0];

endmodule : left_shift_1b_shl1_core

// File: rtl/left_shift_1b.sv
// -----------------------------------------------------------------------------
// left_shift_1b
// Registered shift-left-by-one for the immediate path (word offset -> byte
// offset). Result, carry and zero flag appear one clock after the operand is
// sampled; out_valid marks the cycle a fresh result is presented.
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-high reset
//   bus   slave modport of left_shift_1b_if (operand in, result/flags out)
// -----------------------------------------------------------------------------
module left_shift_1b
    import left_shift_1b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    left_shift_1b_if.slave    bus
);

    logic [WIDTH-1:0] shifted;
    logic             shifted_carry;
    logic             shifted_zero;

    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             zero_q;
    logic             valid_q;

    left_shift_1b_shl1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .immediate (bus.immediate),
        .shifted   (shifted),
        .carry     (shifted_carry),
        .zero      (shifted_zero)
    );

    // NOTE: data registers are reset here (not just the valid flop) because
    // consumers may read out/zero/carry_out directly out of reset, and the
    // zero flag must be consistent with a cleared result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= RESET_ZERO;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            valid_q <= bus.in_valid;
            // Load only on a qualified operand; an X on immediate while
            // in_valid is low never reaches the held result.
            if (bus.in_valid) begin
                out_q   <= shifted;
                carry_q <= shifted_carry;
                zero_q  <= shifted_zero;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;

endmodule : left_shift_1b

// File: tb/tb_left_shift_1b.sv
// -----------------------------------------------------------------------------
// tb_left_shift_1b
// Self-checking bench for left_shift_1b: asynchronous reset, a vector table of
// directed operands with hold cycles, mid-stream reset sequences, and a
// randomized run compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_left_shift_1b;
    import left_shift_1b_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    typedef struct {
        logic [W-1:0] imm;
        logic         vld;
        logic [W-1:0] e_out;
        logic         e_valid;
        logic         e_carry;
        logic         e_zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    left_shift_1b_if #(.WIDTH(W)) bus ();

    left_shift_1b #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] e_out,
                              input logic e_v, input logic e_c, input logic e_z);
        check({tag, ".out"},       bus.out,             e_out);
        check({tag, ".out_valid"}, W'(bus.out_valid),   W'(e_v));
        check({tag, ".carry_out"}, W'(bus.carry_out),   W'(e_c));
        check({tag, ".zero"},      W'(bus.zero),        W'(e_z));
    endtask

    // Drive an operand in the low clock phase, then sample 1 time unit after
    // the following rising edge.
    task automatic drive(input logic [W-1:0] imm, input logic v);
        @(negedge clk);
        bus.immediate = imm;
        bus.in_valid  = v;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [9];

    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_carry;
    logic         m_zero;
    logic [W-1:0] r_imm;
    logic         r_vld;
    longint       prod;

    initial begin
        // Directed vectors: back-to-back loads, then a hold with the operand
        // changing (including X) while in_valid is low.
        vecs[0] = '{16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h000C, 1'b1, 16'h0018, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFB, 1'b1, 16'hFFF6, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 1'b1, 16'h2468, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 1'b0, 16'h2468, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'hxxxx, 1'b0, 16'h2468, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 1'b0, 16'h2468, 1'b0, 1'b0, 1'b0};

        bus.immediate = '0;
        bus.in_valid  = 1'b0;

        // Reset asserted before any clock edge: outputs must clear at once.
        #1 rst = 1'b1;
        #1;
        check_outs("reset_async", 16'h0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("reset_release", 16'h0000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].imm, vecs[i].vld);
            check_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                       vecs[i].e_carry, vecs[i].e_zero);
        end

        // Reset mid-stream: result in flight must be discarded immediately.
        drive(16'h00FF, 1'b1);
        check_outs("mid_load", 16'h01FE, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_outs("mid_rst_async", 16'h0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outs("mid_rst_held", 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("mid_idle_after_rel", 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(16'h0003, 1'b1);
        check_outs("mid_first_result", 16'h0006, 1'b1, 1'b0, 1'b0);

        // in_valid already high on the first edge with rst low.
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.immediate = 16'h0007;
        #1;
        check_outs("rel_valid_rst", 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outs("rel_valid_first", 16'h000E, 1'b1, 1'b0, 1'b0);

        // Randomized run against the arithmetic model: result = 2*imm mod 2^W.
        m_out   = 16'h000E;
        m_valid = 1'b1;
        m_carry = 1'b0;
        m_zero  = 1'b0;
        for (int n = 0; n < 300; n++) begin
            r_imm = W'($urandom);
            if (n % 17 == 0) r_imm = (n % 34 == 0) ? 16'h8000 : 16'h0000;
            r_vld = ($urandom_range(3) != 0);
            drive(r_imm, r_vld);
            if (r_vld) begin
                prod    = longint'(r_imm) * 2;
                m_out   = W'(prod % (longint'(1) << W));
                m_carry = (longint'(r_imm) >= (longint'(1) << (W - 1)));
                m_zero  = (m_out == 0);
            end
            m_valid = r_vld;
            check_outs($sformatf("rand%0d", n), m_out, m_valid, m_carry, m_zero);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_left_shift_1b
